lab3_mem_latency_responder: RTL and testbench
=============================================

Name: lab3_mem_latency_responder

Overview:
Memory-side responder for the 4B memory request/response protocol (mem_req_4B_t in, mem_resp_4B_t out). It terminates the request stream issued by a cache or pass-through cache wrapper. It holds a word-addressed backing store, applies each request at acceptance, and returns in-order responses after a fixed minimum latency. A bounded response queue absorbs downstream backpressure. It is the stand-in for main memory in lab3 cache test harnesses.

Parameters:
NUM_WORDS, 256, backing-store depth in 32-bit words; power of two, >= 2.
LATENCY, 2, minimum number of cycles from request acceptance to response valid; >= 1.
QDEPTH, 4, maximum number of accepted-but-undelivered requests; power of two, >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
memreq_val  input  1  request valid.
memreq_rdy  output  1  request ready.
memreq_msg  input  77  mem_req_4B_t: type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0].
memresp_val  output  1  response valid.
memresp_rdy  input  1  response ready.
memresp_msg  output  47  mem_resp_4B_t: type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0].

Behaviour:
- Reset (reset==0, asynchronous): queue empty, count=0, memreq_rdy=0 while reset is held, memresp_val=0, memresp_msg=0. Backing store is not cleared; its contents are undefined until written or initialised.
- Handshake: a request is accepted in cycle T when memreq_val && memreq_rdy. A response is delivered when memresp_val && memresp_rdy.
- Once out of reset, memreq_rdy = (count < QDEPTH). It is registered-state only, with no combinational path from memresp_rdy or memreq_val.
- Store indexing: index = addr[2+log2(NUM_WORDS)-1 : 2]. Upper address bits are ignored, so addresses wrap. off = addr[1:0].
- Byte count: nbytes = (len==0) ? 4 : len.
- Store update: write (type 1) and init (type 2) update bytes off .. min(off+nbytes,4)-1 of the indexed word from data[8*nbytes-1:0] at the accept edge. Bytes that would fall past byte 3 are dropped.
- Read (type 0): rdata = (word >> 8*off), with bits at or above 8*nbytes forced to 0. The read samples the store in cycle T, before that cycle's write edge, so it is ordered after all earlier-accepted writes.
- Response fields: type = request type; opaque = request opaque; test = 0; len = request len; data = rdata for reads and 0 otherwise.
- Other types (3..7): no store change; response carries the echoed type and data = 0.
- Queue: circular FIFO of QDEPTH entries, each holding the response message plus a countdown initialised to LATENCY-1. Every occupied entry's countdown decrements each cycle, saturating at 0.
- memresp_val = queue non-empty && head countdown == 0. memresp_msg = head message (0 when the queue is empty).
- Latency: a response accepted in T is valid no earlier than T+LATENCY, and exactly at T+LATENCY if it is at the head and the queue is not stalled. Responses stay in acceptance order.
- Simultaneous enqueue and dequeue in one cycle: count is unchanged and pointers advance independently.
- Full queue: memreq_rdy=0 until a delivery occurs; the cycle after that delivery, memreq_rdy=1.
- Pointer wrap: wrap modulo QDEPTH.
- Holding a response: memresp_msg is stable while memresp_val=1 && memresp_rdy=0.
- Reset mid-operation: all queued responses are discarded, and no response for them appears after reset deasserts.

Test Plan:
1. Init addr 0x100 with data 0xDEADBEEF, len 0; then read addr 0x100, len 0, opaque 0x05. Required: init response type 2 with data 0; read response type 0, opaque 0x05, data 0xDEADBEEF, valid exactly 2 cycles after acceptance (LATENCY=2).
2. After test 1, write addr 0x101, len 1, data 0xAA; then read addr 0x100, len 0. Required: data 0xDEADAAEF. Read addr 0x102, len 2. Required: data 0x0000DEAD.
3. Hold memresp_rdy=0 and issue 5 back-to-back reads (QDEPTH=4). Required: memreq_rdy drops after the 4th accept. Raise memresp_rdy. Required: the 4 responses come out in opaque order 0,1,2,3; the 5th is accepted the cycle after the first delivery.
4. Continuous val/rdy=1 streaming of 16 reads. Required: one accept and one response per cycle at steady state, and 16 correct responses in order as the FIFO pointers wrap.
5. Write addr 0x0 with 0x11223344, then access addr 0x400 with NUM_WORDS=256. Required: index wrap, so a read of 0x400 returns 0x11223344.
6. Pull reset low with 3 responses queued. Required: memresp_val=0 immediately. After release, memresp_val stays 0 until a new request is accepted; store contents are preserved.

Source files
------------

// File: rtl/lab3_mem_latency_responder.sv
// lab3_mem_latency_responder
//   Memory-side responder for the 4B request/response protocol. It holds a
//   word-addressed backing store, applies each request when it is accepted,
//   and returns in-order responses no earlier than LATENCY cycles after
//   acceptance. A QDEPTH-entry response FIFO absorbs downstream backpressure.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   memreq_val   request valid
//   memreq_rdy   request ready (depends on registered state and reset only)
//   memreq_msg   {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
//   memresp_val  response valid
//   memresp_rdy  response ready
//   memresp_msg  {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}
module lab3_mem_latency_responder #(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [76:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [46:0] memresp_msg
);

  localparam int unsigned IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNTW = $clog2(QDEPTH + 1);
  localparam int unsigned CDW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Request field split
  logic [2:0]  req_type;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;

  assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;

  // Upper address bits are intentionally ignored (addresses wrap).
  logic unused_addr;
  assign unused_addr = ^req_addr;

  logic accept;
  logic deliver;

  // Backing store (not reset)
  logic [31:0]     store_q [NUM_WORDS];
  logic [IDXW-1:0] idx;
  logic [4:0]      off_bits;
  logic [31:0]     word_rd;
  logic [31:0]     len_mask;
  logic [31:0]     wr_mask;
  logic [31:0]     wword;
  logic [31:0]     rdata;
  logic            is_store;
  logic [46:0]     resp_msg;

  assign idx      = req_addr[IDXW+1:2];
  assign off_bits = {req_addr[1:0], 3'b000};
  assign word_rd  = store_q[idx];

  // Low 8*nbytes bits set; len==0 means a full word.
  assign len_mask = (req_len == 2'd0) ? '1 : ((32'd1 << {req_len, 3'b000}) - 32'd1);

  // Shifting the mask/data up by the byte offset drops bytes past byte 3.
  assign wr_mask  = len_mask << off_bits;
  assign wword    = (word_rd & ~wr_mask) | ((req_data << off_bits) & wr_mask);
  assign rdata    = (word_rd >> off_bits) & len_mask;
  assign is_store = (req_type == 3'd1) || (req_type == 3'd2);

  assign resp_msg = {req_type, req_opaque, 2'b00, req_len,
                     (req_type == 3'd0) ? rdata : 32'h0};

  always_ff @(posedge clk) begin
    if (accept && is_store) begin
      store_q[idx] <= wword;
    end
  end

  // Response FIFO
  logic [46:0]     msg_q [QDEPTH];
  logic [CDW-1:0]  cd_q  [QDEPTH];
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(QDEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign memreq_rdy  = reset && (count_q < CNTW'(QDEPTH));
  assign memresp_val = (count_q != '0) && (cd_q[rptr_q] == '0);
  assign memresp_msg = (count_q != '0) ? msg_q[rptr_q] : '0;
  assign accept      = memreq_val && memreq_rdy;
  assign deliver     = memresp_val && memresp_rdy;

  always_comb begin
    wptr_d  = accept  ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = deliver ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (accept && !deliver) begin
      count_d = count_q + CNTW'(1);
    end else if (!accept && deliver) begin
      count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        msg_q[i] <= '0;
        cd_q[i]  <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // Every countdown ticks each cycle; free slots are overwritten on enqueue,
      // so ticking them too is harmless.
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (accept && (wptr_q == PTRW'(i))) begin
          msg_q[i] <= resp_msg;
          cd_q[i]  <= CDW'(LATENCY - 1);
        end else if (cd_q[i] != '0) begin
          cd_q[i] <= cd_q[i] - CDW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lab3_mem_latency_responder.sv
// Testbench for lab3_mem_latency_responder: directed scenarios followed by a
// randomized phase. A byte-level reference store predicts each response when
// a request is accepted; a monitor compares responses and their timing.
module tb_lab3_mem_latency_responder;

  localparam int unsigned NUM_WORDS = 256;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned QDEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [76:0] memreq_msg;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [46:0] memresp_msg;

  lab3_mem_latency_responder #(
    .NUM_WORDS(NUM_WORDS),
    .LATENCY  (LATENCY),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memreq_msg (memreq_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .memresp_msg(memresp_msg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [46:0] msg;
    int          t;
  } exp_t;

  exp_t       sbq[$];
  int         del_cycles[$];
  logic [7:0] mb [NUM_WORDS*4];
  int         n_chk = 0;
  int         n_fail = 0;
  int         last_del = -100;
  bit         head_seen = 0;
  bit         stop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [76:0] mk(input logic [2:0] ty, input logic [7:0] op,
                                     input logic [31:0] addr, input logic [1:0] len,
                                     input logic [31:0] data);
    return {ty, op, addr, len, data};
  endfunction

  // Reference: byte-addressed store, bytes off..off+nbytes-1 of a word.
  function automatic logic [46:0] model(input logic [76:0] m);
    logic [2:0]  ty   = m[76:74];
    logic [7:0]  op   = m[73:66];
    logic [31:0] addr = m[65:34];
    logic [1:0]  len  = m[33:32];
    logic [31:0] data = m[31:0];
    int          base = int'((addr >> 2) % NUM_WORDS) * 4;
    int          off  = int'(addr[1:0]);
    int          nb   = (len == 2'd0) ? 4 : int'(len);
    logic [31:0] rd   = 32'h0;
    for (int k = 0; k < nb; k++) begin
      if (off + k < 4) begin
        if (ty == 3'd0) rd[8*k +: 8] = mb[base + off + k];
        if (ty == 3'd1 || ty == 3'd2) mb[base + off + k] = data[8*k +: 8];
      end
    end
    return {ty, op, 2'b00, len, (ty == 3'd0) ? rd : 32'h0};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [76:0] m, input bit use_exp, input logic [31:0] exp_data,
                      output int t_acc);
    bit   r;
    int   waited = 0;
    exp_t e;
    memreq_val = 1'b1;
    memreq_msg = m;
    t_acc = -1;
    forever begin
      r = memreq_rdy;
      t_acc = cyc;
      @(posedge clk);
      if (r) begin
        e.msg = model(m);
        if (use_exp) e.msg[31:0] = exp_data;
        e.t = t_acc;
        sbq.push_back(e);
        #1;
        break;
      end
      #1;
      waited++;
      if (waited > 1000) begin
        n_chk++;
        n_fail++;
        $display("FAIL req_accept_timeout: got no accept expected accept within 1000 cycles");
        t_acc = -1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    memreq_val = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares the head response and checks when it becomes valid.
  always @(negedge clk) begin
    int exp_c;
    if (!reset) begin
      chk("reset_outputs", 64'({memreq_rdy, memresp_val, memresp_msg}), 64'h0);
    end else if (sbq.size() == 0) begin
      chk("idle_outputs", 64'({memresp_val, memresp_msg}), 64'h0);
      head_seen = 0;
    end else begin
      exp_c = sbq[0].t + int'(LATENCY);
      if (last_del + 1 > exp_c) exp_c = last_del + 1;
      if (head_seen) begin
        chk("valid_held", 64'(memresp_val), 64'h1);
      end else begin
        chk("resp_timing", 64'(memresp_val), 64'(cyc >= exp_c));
        if (memresp_val) head_seen = 1;
      end
      if (memresp_val) begin
        chk("resp_msg", 64'(memresp_msg), 64'(sbq[0].msg));
        if (memresp_rdy) begin
          void'(sbq.pop_front());
          head_seen = 0;
          last_del = cyc;
          del_cycles.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t5, n0, w;
    int ts[16];
    logic [31:0] a;
    logic [2:0]  ty;
    int sel;

    reset       = 1'b0;
    memreq_val  = 1'b0;
    memreq_msg  = '0;
    memresp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: init then read back
    memresp_rdy = 1'b1;
    send(mk(3'd2, 8'h01, 32'h100, 2'd0, 32'hDEADBEEF), 1, 32'h0, t);
    send(mk(3'd0, 8'h05, 32'h100, 2'd0, 32'h0), 1, 32'hDEADBEEF, t);
    idle(4);

    // 2: sub-word write and sub-word reads
    send(mk(3'd1, 8'h06, 32'h101, 2'd1, 32'h000000AA), 1, 32'h0, t);
    send(mk(3'd0, 8'h07, 32'h100, 2'd0, 32'h0), 1, 32'hDEADAAEF, t);
    send(mk(3'd0, 8'h08, 32'h102, 2'd2, 32'h0), 1, 32'h0000DEAD, t);
    idle(4);

    // 3: fill the queue under backpressure
    memresp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(3'd0, 8'(i), 32'h100, 2'd0, 32'h0), 0, 32'h0, t);
    chk("rdy_after_4th", 64'(memreq_rdy), 64'h0);
    n0 = 0;
    fork
      send(mk(3'd0, 8'h04, 32'h100, 2'd0, 32'h0), 0, 32'h0, t5);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        chk("rdy_while_full", 64'(memreq_rdy), 64'h0);
        n0 = del_cycles.size();
        memresp_rdy = 1'b1;
      end
    join
    if (del_cycles.size() > n0) chk("fifth_accept_cycle", 64'(t5), 64'(del_cycles[n0] + 1));
    else chk("fifth_accept_cycle", 64'(del_cycles.size()), 64'(n0 + 1));
    idle(6);

    // 4: streaming through pointer wrap
    memresp_rdy = 1'b1;
    n0 = del_cycles.size();
    for (int i = 0; i < 16; i++) begin
      send(mk(3'd0, 8'(8'h10 + i), 32'h100 + 32'(i % 4), 2'(i % 4), 32'h0), 0, 32'h0, t);
      ts[i] = t;
    end
    idle(LATENCY + 4);
    chk("stream_accept_span", 64'(ts[15] - ts[0]), 64'd15);
    if (del_cycles.size() >= n0 + 16)
      chk("stream_deliver_span", 64'(del_cycles[n0+15] - del_cycles[n0]), 64'd15);
    else
      chk("stream_deliver_count", 64'(del_cycles.size() - n0), 64'd16);

    // 5: index wrap
    send(mk(3'd1, 8'h20, 32'h0, 2'd0, 32'h11223344), 1, 32'h0, t);
    send(mk(3'd0, 8'h21, 32'h400, 2'd0, 32'h0), 1, 32'h11223344, t);
    idle(4);

    // 6: reset with responses queued
    memresp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(3'd0, 8'(8'h30 + i), 32'h100, 2'd0, 32'h0), 0, 32'h0, t);
    idle(3);
    reset = 1'b0;
    sbq.delete();
    head_seen = 0;
    #1;
    chk("val_on_reset", 64'(memresp_val), 64'h0);
    chk("rdy_on_reset", 64'(memreq_rdy), 64'h0);
    memresp_rdy = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    idle(5);
    send(mk(3'd0, 8'h40, 32'h100, 2'd0, 32'h0), 1, 32'hDEADAAEF, t);
    send(mk(3'd0, 8'h41, 32'h0, 2'd0, 32'h0), 1, 32'h11223344, t);
    idle(4);

    // Random phase over words 0..15 with random upper address bits
    for (int i = 0; i < 16; i++) begin
      a = $urandom();
      a[9:2] = 8'(i);
      a[1:0] = 2'b00;
      send(mk(3'd2, 8'($urandom()), a, 2'd0, $urandom()), 0, 32'h0, t);
    end
    stop = 0;
    fork
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          memresp_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) ty = 3'd0;
      else if (sel < 7) ty = 3'd1;
      else if (sel == 7) ty = 3'd2;
      else ty = 3'($urandom_range(3, 7));
      a = $urandom();
      a[9:2] = 8'($urandom_range(0, 15));
      send(mk(ty, 8'($urandom()), a, 2'($urandom_range(0, 3)), $urandom()), 0, 32'h0, t);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    memreq_val = 1'b0;
    stop = 1;
    @(posedge clk);
    #2;
    memresp_rdy = 1'b1;
    w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'h0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
